// File: rtl/snoop_pkg.sv
// snoop_pkg: definitions shared by the store snooper.
//   MW_*          bit positions inside the CPU MemWr strobe
//   size_e        size code of a captured store (0 byte, 1 half, 2 word)
//   halt_state_e  state encoding of the halt detector
//   entry_t       one FIFO entry: window offset, size and masked data
//   mask_data()   zeroes the bytes that a byte or half store does not write
package snoop_pkg;

  localparam int MW_WORD = 0;
  localparam int MW_HALF = 1;
  localparam int MW_BYTE = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_e;

  typedef struct packed {
    logic [4:0]  off;
    size_e       size;
    logic [31:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [31:0] mask_data(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {24'd0, d[7:0]};
      SZ_HALF: return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/store_snoop_if.sv
// store_snoop_if: valid/ready stream of captured stores.
//   out_valid  head entry present
//   out_ready  consumer takes the head on this rising edge
//   out_off    head byte offset inside the watched window
//   out_size   head size code (0 byte, 1 half, 2 word)
//   out_data   head data, right-aligned, unused upper bits zero
// master: the snooper (producer); slave: the consumer.
interface store_snoop_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_off;
  logic [1:0]  out_size;
  logic [31:0] out_data;

  modport master (output out_valid, out_off, out_size, out_data, input out_ready);
  modport slave  (input out_valid, out_off, out_size, out_data, output out_ready);
endinterface

// File: rtl/snoop_fifo.sv
// snoop_fifo: show-ahead FIFO holding captured stores.
//   Clk      clock, rising edge
//   Reset    asynchronous active-low reset, empties the FIFO
//   wr_en    push request; accepted when not full, or when full and a pop
//            happens on the same edge
//   wr_data  entry to push
//   rd_en    pop request; ignored while empty
//   rd_data  current head (meaningful only while !empty)
//   empty    no entries
//   full     DEPTH entries
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module snoop_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 39
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  // A pop frees the slot the push lands in, so full does not block a
  // simultaneous push.
  assign wr_fire = wr_en && (!full || rd_fire);

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge Clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Small and shallow: the head is read directly so it is visible the cycle
  // after the write without a bypass path.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/store_snoop.sv
// store_snoop: watches CPU stores into a 32-byte window and queues them,
// and detects a halted CPU by a PC that stops changing.
//   Clk        clock, rising edge
//   Reset      asynchronous active-low reset
//   MemWr      one-hot store strobe ([0] word, [1] half, [2] byte)
//   Addr       store byte address
//   WData      store data, right-aligned
//   PC         current program counter
//   out_if     captured-store stream (master side)
//   overflow   sticky: a window store was dropped on a full FIFO
//   bad_strobe sticky: MemWr had more than one bit set
//   halted     sticky: PC stayed unchanged for HALT_CYCLES edges
//   cycle_cnt  edges counted while running, frozen once halted, saturating
module store_snoop
  import snoop_pkg::*;
#(
  parameter logic [15:0] WIN_BASE    = 16'hFFE0,
  parameter int          DEPTH       = 8,
  parameter int          HALT_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [2:0]          MemWr,
  input  logic [31:0]         Addr,
  input  logic [31:0]         WData,
  input  logic [31:0]         PC,
  store_snoop_if.master       out_if,
  output logic                overflow,
  output logic                bad_strobe,
  output logic                halted,
  output logic [31:0]         cycle_cnt
);

  localparam logic [7:0] HALT_LAST = 8'(HALT_CYCLES - 1);

  logic        strobe_onehot;
  logic        strobe_multi;
  logic        in_window;
  logic        capture;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  size_e       cap_size;
  entry_t      cap_entry;
  logic [ENTRY_W-1:0] head_bits;
  entry_t      head;

  logic        overflow_reg;
  logic        bad_strobe_reg;
  halt_state_e state_reg;
  logic        halted_reg;
  logic [31:0] prev_pc_reg;
  logic [7:0]  stab_cnt_reg;
  logic [31:0] cycle_cnt_reg;

  // ---------------- capture decode ----------------
  assign strobe_onehot = $onehot(MemWr);
  assign strobe_multi  = (MemWr != 3'b000) && !strobe_onehot;
  assign in_window     = (Addr[31:16] == 16'd0) && (Addr[15:5] == WIN_BASE[15:5]);
  assign capture       = strobe_onehot && in_window;

  always_comb begin
    cap_size = SZ_BYTE;
    if (MemWr[MW_WORD])      cap_size = SZ_WORD;
    else if (MemWr[MW_HALF]) cap_size = SZ_HALF;
    cap_entry      = '0;
    cap_entry.off  = Addr[4:0];
    cap_entry.size = cap_size;
    cap_entry.data = mask_data(cap_size, WData);
  end

  // ---------------- FIFO ----------------
  snoop_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (capture),
    .wr_data (cap_entry),
    .rd_en   (out_if.out_ready),
    .rd_data (head_bits),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign head = entry_t'(head_bits);
  assign pop  = !fifo_empty && out_if.out_ready;

  // Fields are forced to zero when nothing is queued, which also covers reset.
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_off   = fifo_empty ? 5'd0  : head.off;
  assign out_if.out_size  = fifo_empty ? 2'd0  : head.size;
  assign out_if.out_data  = fifo_empty ? 32'd0 : head.data;

  // ---------------- sticky flags ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overflow_reg   <= 1'b0;
      bad_strobe_reg <= 1'b0;
    end else begin
      if (capture && fifo_full && !pop) overflow_reg <= 1'b1;
      if (strobe_multi)                 bad_strobe_reg <= 1'b1;
    end
  end

  // ---------------- halt detector ----------------
  // prev_pc starts at zero, so a PC of zero on the first edge already counts
  // as one stable edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_RUN;
      halted_reg    <= 1'b0;
      prev_pc_reg   <= '0;
      stab_cnt_reg  <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      prev_pc_reg <= PC;
      case (state_reg)
        ST_RUN: begin
          if (cycle_cnt_reg != 32'hFFFF_FFFF) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
          if (PC == prev_pc_reg) begin
            // The edge that completes the stable run is the one that halts.
            if (stab_cnt_reg == HALT_LAST) begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              stab_cnt_reg <= stab_cnt_reg + 8'd1;
            end
          end else begin
            stab_cnt_reg <= '0;
          end
        end
        ST_HALT: begin
          // Terminal until reset.
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign overflow   = overflow_reg;
  assign bad_strobe = bad_strobe_reg;
  assign halted     = halted_reg;
  assign cycle_cnt  = cycle_cnt_reg;

endmodule

// File: tb/tb_store_snoop.sv
// tb_store_snoop: directed scenarios plus randomized stores against a
// queue-based reference model; a negedge monitor compares every output.
module tb_store_snoop;

  localparam logic [15:0] WIN_BASE    = 16'hFFE0;
  localparam int          DEPTH       = 8;
  localparam int          HALT_CYCLES = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  MemWr = 3'b000;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic [31:0] PC = '0;
  logic        overflow;
  logic        bad_strobe;
  logic        halted;
  logic [31:0] cycle_cnt;

  store_snoop_if sif ();

  store_snoop #(
    .WIN_BASE    (WIN_BASE),
    .DEPTH       (DEPTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MemWr      (MemWr),
    .Addr       (Addr),
    .WData      (WData),
    .PC         (PC),
    .out_if     (sif),
    .overflow   (overflow),
    .bad_strobe (bad_strobe),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  off;
    logic [1:0]  size;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          failures = 0;

  // Reference model state.
  exp_t        exp_q[$];
  int          model_cnt = 0;
  logic        ovf_m = 1'b0;
  logic        bad_m = 1'b0;
  logic        halted_m = 1'b0;
  logic [31:0] cnt_m = '0;
  logic [31:0] prev_pc_m = '0;
  int          run_m = 0;

  logic        pc_hold = 1'b0;
  logic [31:0] pc_next = 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_cnt = 0;
    ovf_m = 1'b0;
    bad_m = 1'b0;
    halted_m = 1'b0;
    cnt_m = '0;
    prev_pc_m = '0;
    run_m = 0;
  endtask

  // Model: a bounded queue of window stores plus a stable-PC run counter.
  always @(posedge Clk) begin
    if (Reset) begin : model_step
      logic        pop_m;
      logic        cap_m;
      logic [1:0]  sz;
      logic [31:0] mask;
      logic [31:0] offw;
      pop_m = (model_cnt > 0) && sif.out_ready;
      cap_m = ($countones(MemWr) == 1) && (Addr >= 32'(WIN_BASE)) && (Addr < 32'(WIN_BASE) + 32);
      if ($countones(MemWr) > 1) bad_m = 1'b1;
      if (MemWr == 3'b001)      begin sz = 2'd2; mask = 32'hFFFF_FFFF; end
      else if (MemWr == 3'b010) begin sz = 2'd1; mask = 32'h0000_FFFF; end
      else                      begin sz = 2'd0; mask = 32'h0000_00FF; end
      offw = Addr - 32'(WIN_BASE);
      if (pop_m) model_cnt--;
      if (cap_m) begin
        if (model_cnt < DEPTH) begin
          model_cnt++;
          exp_q.push_back('{offw[4:0], sz, WData & mask});
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (!halted_m) begin
        if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
        if (PC == prev_pc_m) run_m++;
        else run_m = 0;
        if (run_m >= HALT_CYCLES) halted_m = 1'b1;
      end
      prev_pc_m = PC;
    end
  end

  // Monitor: compares the stream head and the flags once per cycle.
  always @(negedge Clk) begin
    chk("out_valid", sif.out_valid, 32'(exp_q.size() != 0));
    if (sif.out_valid && exp_q.size() != 0) begin
      chk("out_off",  sif.out_off,  exp_q[0].off);
      chk("out_size", sif.out_size, exp_q[0].size);
      chk("out_data", sif.out_data, exp_q[0].data);
    end
    if (!Reset) begin
      chk("rst_off",  sif.out_off,  0);
      chk("rst_data", sif.out_data, 0);
    end
    chk("overflow",   overflow,   ovf_m);
    chk("bad_strobe", bad_strobe, bad_m);
    chk("halted",     halted,     halted_m);
    chk("cycle_cnt",  cycle_cnt,  cnt_m);
    if (sif.out_valid && sif.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  // Applies one cycle of inputs, returns 1 time unit after the sampling edge.
  task automatic drive(input logic [2:0] mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy);
    MemWr = mw;
    Addr = a;
    WData = d;
    sif.out_ready = rdy;
    PC = pc_hold ? 32'h0000_003C : pc_next;
    pc_next = pc_next + 4;
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_cycles(input int n, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      logic [2:0]  mw;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: mw = 3'b000;
        1: mw = 3'b001;
        2: mw = 3'b010;
        default: mw = 3'b100;
      endcase
      if ($urandom_range(0, 3) != 0) a = 32'(WIN_BASE) + $urandom_range(0, 31);
      else if ($urandom_range(0, 1) != 0) a = 32'hFFC0 + $urandom_range(0, 127);
      else a = $urandom | 32'h0001_0000;
      drive(mw, a, $urandom, $urandom_range(0, 99) < rdy_pct);
    end
  endtask

  initial begin
    sif.out_ready = 1'b0;
    reset_model();
    #2;
    chk("reset_valid",     sif.out_valid, 0);
    chk("reset_off",       sif.out_off,   0);
    chk("reset_size",      sif.out_size,  0);
    chk("reset_data",      sif.out_data,  0);
    chk("reset_overflow",  overflow,      0);
    chk("reset_bad",       bad_strobe,    0);
    chk("reset_halted",    halted,        0);
    chk("reset_cycle_cnt", cycle_cnt,     0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;

    // Word store, popped on the following edge.
    drive(3'b001, 32'h0000_FFEC, 32'h0000_002A, 1'b1);
    chk("sw_valid", sif.out_valid, 1);
    chk("sw_off",   sif.out_off,   5'h0C);
    chk("sw_size",  sif.out_size,  2);
    chk("sw_data",  sif.out_data,  32'h2A);
    drive(3'b000, 0, 0, 1'b1);
    chk("sw_popped", sif.out_valid, 0);

    // Byte store masked; stores outside the window ignored.
    drive(3'b100, 32'h0000_FFE3, 32'h1234_ABCD, 1'b1);
    chk("sb_data", sif.out_data, 32'h0000_00CD);
    chk("sb_off",  sif.out_off,  5'h03);
    chk("sb_size", sif.out_size, 0);
    drive(3'b001, 32'h0000_FFDC, 32'h55, 1'b1);
    chk("below_window", sif.out_valid, 0);
    drive(3'b001, 32'h0001_FFEC, 32'h66, 1'b1);
    chk("upper_addr", sif.out_valid, 0);

    // Full FIFO with simultaneous pop and push: no overflow.
    for (int i = 0; i < DEPTH; i++) drive(3'b001, 32'(WIN_BASE) + 32'(4 * i), 32'h100 + i, 1'b0);
    drive(3'b010, 32'h0000_FFFE, 32'h0000_1108, 1'b1);
    chk("full_pop_push_ovf", overflow, 0);
    chk("full_pop_push_valid", sif.out_valid, 1);
    repeat (DEPTH + 2) drive(3'b000, 0, 0, 1'b1);

    // Nine stores with no consumer: eight kept, overflow set.
    for (int i = 0; i < 9; i++) drive(3'b001, 32'(WIN_BASE) + 32'(4 * (i % 8)), 32'(i + 1), 1'b0);
    chk("nine_overflow", overflow, 1);
    repeat (DEPTH + 2) drive(3'b000, 0, 0, 1'b1);

    rand_cycles(300, 60);
    repeat (DEPTH + 2) drive(3'b000, 0, 0, 1'b1);

    // Reset mid-drain with five entries queued.
    for (int i = 0; i < 5; i++) drive(3'b010, 32'(WIN_BASE) + 32'(2 * i), 32'hA_0000 + i, 1'b0);
    sif.out_ready = 1'b1;
    Reset = 1'b0;
    reset_model();
    #1;
    chk("midrst_valid",    sif.out_valid, 0);
    chk("midrst_overflow", overflow,      0);
    chk("midrst_halted",   halted,        0);
    chk("midrst_cnt",      cycle_cnt,     0);
    chk("midrst_data",     sif.out_data,  0);
    drive(3'b000, 0, 0, 1'b1);
    drive(3'b000, 0, 0, 1'b1);
    Reset = 1'b1;
    pc_next = 32'h200;
    drive(3'b000, 0, 0, 1'b1);
    chk("post_rst_cycle1", cycle_cnt, 1);
    chk("post_rst_stale",  sif.out_valid, 0);

    // PC held at 0x3C from cycle 20: halts on cycle 24.
    rand_cycles(18, 70);
    pc_hold = 1'b1;
    rand_cycles(4, 70);
    chk("halt_not_yet", halted, 0);
    rand_cycles(1, 70);
    chk("halt_set",    halted,    1);
    chk("halt_cnt_24", cycle_cnt, 24);
    drive(3'b011, 32'(WIN_BASE), 32'h77, 1'b1);
    chk("bad_strobe_set", bad_strobe, 1);
    pc_hold = 1'b0;
    rand_cycles(60, 70);
    chk("halt_cnt_frozen", cycle_cnt, 24);
    chk("halt_sticky",     halted,    1);
    repeat (DEPTH + 2) drive(3'b000, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
